// File: rtl/lfsr_pkg.sv
// Shared constants for the Galois LFSR generator family: default primitive
// feedback masks and all-ones start values for the commonly used widths.
package lfsr_pkg;

  localparam logic [5:0]  POLY_6  = 6'b000011;
  localparam logic [7:0]  POLY_8  = 8'b00011101;
  localparam logic [15:0] POLY_16 = 16'h002D;
  localparam logic [31:0] POLY_32 = 32'h000000AF;

  localparam logic [5:0]  DEFAULT_SEED_6  = '1;
  localparam logic [7:0]  DEFAULT_SEED_8  = '1;
  localparam logic [15:0] DEFAULT_SEED_16 = '1;
  localparam logic [31:0] DEFAULT_SEED_32 = '1;

endpackage

// File: rtl/lfsr_next.sv
// Galois LFSR next-state function: shift left and fold the feedback mask in
// whenever the MSB falls off. Purely combinational so other scramblers can reuse it.
module lfsr_next #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = 6'b000011
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with step enable, seed load with zero-seed rejection,
// a step counter relative to the start value, and a wrap pulse on sequence return.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = POLY_6,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED_6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             lockup
);

  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] nxt;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .q   (q),
    .nxt (nxt)
  );

  // A zero seed would freeze the LFSR forever, so it falls back to SEED and flags lockup.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= SEED;
      start  <= SEED;
      cnt    <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (load) begin
      if (load_val != '0) begin
        q      <= load_val;
        start  <= load_val;
        lockup <= 1'b0;
      end else begin
        q      <= SEED;
        start  <= SEED;
        lockup <= 1'b1;
      end
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      q      <= nxt;
      lockup <= 1'b0;
      if (nxt == start) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else begin
        cnt  <= cnt + WIDTH'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default 6-bit instance plus an 8-bit x^8+x^4+x^3+x^2+1 instance.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [5:0] load_val;
  logic [5:0] q, cnt;
  logic       wrap, lockup;

  logic       en8, load8;
  logic [7:0] load_val8;
  logic [7:0] q8, cnt8;
  logic       wrap8, lockup8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .q(q), .cnt(cnt), .wrap(wrap), .lockup(lockup)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .load(load8), .load_val(load_val8),
    .q(q8), .cnt(cnt8), .wrap(wrap8), .lockup(lockup8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    step();
    rst = 1'b0;
  endtask

  logic [63:0] seen;
  int          distinct, zeros, wraps, wrap_at;
  logic [5:0]  q_at_wrap;

  initial begin
    en8 = 1'b0; load8 = 1'b0; load_val8 = '0;
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_q", q, 6'h3F);
    chk("rst_cnt", cnt, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_q8", q8, 8'h01);

    // first three steps from the default seed
    en = 1'b1;
    step(); chk("t1_q1", q, 6'h3D); chk("t1_cnt1", cnt, 1); chk("t1_wrap1", wrap, 0);
    step(); chk("t1_q2", q, 6'h39); chk("t1_cnt2", cnt, 2); chk("t1_wrap2", wrap, 0);
    step(); chk("t1_q3", q, 6'h31); chk("t1_cnt3", cnt, 3); chk("t1_wrap3", wrap, 0);

    // full period of 63
    do_reset();
    en = 1'b1;
    seen = '0; distinct = 0; zeros = 0; wraps = 0;
    for (int i = 1; i <= 63; i++) begin
      step();
      if (q == 6'h00) zeros++;
      if (!seen[q]) begin seen[q] = 1'b1; distinct++; end
      if (wrap) wraps++;
      if (i == 62) begin
        chk("t2_cnt62", cnt, 62);
        chk("t2_wrap62", wrap, 0);
      end
    end
    chk("t2_q63", q, 6'h3F);
    chk("t2_cnt63", cnt, 0);
    chk("t2_wrap63", wrap, 1);
    chk("t2_distinct", distinct, 63);
    chk("t2_zeros", zeros, 0);
    chk("t2_wraps", wraps, 1);
    step();
    chk("t2_q64", q, 6'h3D);
    chk("t2_cnt64", cnt, 1);
    chk("t2_wrap64", wrap, 0);

    // load beats en, then the sequence wraps back to the loaded value
    load = 1'b1; load_val = 6'h05; en = 1'b1;
    step();
    load = 1'b0;
    chk("t3_q_load", q, 6'h05);
    chk("t3_cnt_load", cnt, 0);
    chk("t3_wrap_load", wrap, 0);
    wraps = 0; wrap_at = 0; q_at_wrap = '0; zeros = 0;
    for (int i = 1; i <= 63; i++) begin
      step();
      if (i == 1) begin
        chk("t3_q1", q, 6'h0A);
        chk("t3_cnt1", cnt, 1);
      end
      if (i == 4) chk("t3_q4", q, 6'h13);
      if (q == 6'h00) zeros++;
      if (wrap) begin
        wraps++;
        if (wrap_at == 0) begin wrap_at = i; q_at_wrap = q; end
      end
    end
    chk("t3_wrap_at", wrap_at, 63);
    chk("t3_q_at_wrap", q_at_wrap, 6'h05);
    chk("t3_wraps", wraps, 1);
    chk("t3_zeros", zeros, 0);

    // zero seed rejected
    en = 1'b0; load = 1'b1; load_val = 6'h00;
    step();
    load = 1'b0;
    chk("t4_q", q, 6'h3F);
    chk("t4_cnt", cnt, 0);
    chk("t4_lockup", lockup, 1);
    chk("t4_wrap", wrap, 0);
    step();
    chk("t4_lockup_clr", lockup, 0);
    chk("t4_q_hold", q, 6'h3F);
    en = 1'b1;
    step();
    chk("t4_q_next", q, 6'h3D);

    // enable gating
    do_reset();
    en = 1'b1; step(); chk("t5_q1", q, 6'h3D); chk("t5_cnt1", cnt, 1);
    en = 1'b0; step(); chk("t5_q2", q, 6'h3D); chk("t5_cnt2", cnt, 1);
    step();            chk("t5_q3", q, 6'h3D); chk("t5_cnt3", cnt, 1);
    en = 1'b1; step(); chk("t5_q4", q, 6'h39); chk("t5_cnt4", cnt, 2);

    // reset beats load and en
    step(); step();
    rst = 1'b1; load = 1'b1; load_val = 6'h12; en = 1'b1;
    step();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    chk("t6_q", q, 6'h3F);
    chk("t6_cnt", cnt, 0);
    chk("t6_wrap", wrap, 0);
    chk("t6_lockup", lockup, 0);

    // 8-bit instance: period 255
    chk("t6_q8_rst", q8, 8'h01);
    en8 = 1'b1;
    step();
    chk("t6_q8_1", q8, 8'h02);
    chk("t6_cnt8_1", cnt8, 1);
    wrap_at = 0;
    for (int i = 2; i <= 300 && wrap_at == 0; i++) begin
      step();
      if (i == 254) chk("t6_cnt8_254", cnt8, 254);
      if (wrap8) wrap_at = i;
    end
    en8 = 1'b0;
    chk("t6_wrap8_at", wrap_at, 255);
    chk("t6_q8_wrap", q8, 8'h01);
    chk("t6_cnt8_wrap", cnt8, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
